// File: rtl/ifetch_unit.sv
// Instruction fetch front end: PC handshake -> in-order imem req/gnt/rvalid -> {pc, inst} buffer for decode.
// Latency: accept at N -> imem_req at N+1; rvalid at M -> inst_valid at M+1 (fall-through buffer).
// Backpressure: pc_ready drops while a request awaits grant, on flush, or when all DEPTH slots are in use.
//
// Ports:
//   clk, rst_n                     clock, asynchronous active-low reset
//   pc_in/pc_valid/pc_ready        fetch address handshake from the PC stage
//   flush                          redirect pulse; kills every older fetch
//   imem_req/imem_addr/imem_gnt    request channel to instruction memory (held until granted)
//   imem_rvalid/imem_rdata         in-order response channel from instruction memory
//   inst_valid/inst_ready/inst/inst_pc  instruction output to decode
module ifetch_unit #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] pc_in,
  input  logic        pc_valid,
  output logic        pc_ready,
  input  logic        flush,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [31:0] inst_pc
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int SW = PW + 3;

  // Pending (not yet granted) request
  logic          req_q, req_d;
  logic          kill_q, kill_d;     // pending request was flushed: its response is already counted as a discard
  logic [31:0]   req_pc_q, req_pc_d;

  // Outstanding (granted, awaiting response) PC queue
  logic [31:0]   opc_q [DEPTH];
  logic [PW-1:0] owr_q, owr_d, ord_q, ord_d;
  logic [CW-1:0] ocnt_q, ocnt_d;

  // Instruction buffer
  logic [31:0]   ipc_q  [DEPTH];
  logic [31:0]   idat_q [DEPTH];
  logic [PW-1:0] iwr_q, iwr_d, ird_q, ird_d;
  logic [CW-1:0] icnt_q, icnt_d;

  // Responses still owed by memory for killed requests
  logic [CW-1:0] disc_cnt_q, disc_cnt_d;

  logic          grant, opush, resp_drop, resp_take, accept, ipop;
  logic [SW-1:0] slots;
  logic [CW-1:0] ocnt_after, disc_after;

  assign grant     = req_q && imem_gnt;
  assign opush     = grant && !kill_q;
  assign resp_drop = imem_rvalid && (disc_cnt_q != '0);
  // A response with nothing outstanding and nothing to discard is ignored.
  assign resp_take = imem_rvalid && (disc_cnt_q == '0) && (ocnt_q != '0);
  assign ipop      = (icnt_q != '0) && inst_ready;

  assign slots    = SW'(req_q) + SW'(ocnt_q) + SW'(icnt_q) + SW'(disc_cnt_q);
  assign pc_ready = !flush && (!req_q || imem_gnt) && (slots < SW'(DEPTH));
  assign accept   = pc_valid && pc_ready;

  // Queue state after this cycle's grant/response, before any flush.
  assign ocnt_after = ocnt_q + CW'(opush) - CW'(resp_take);
  assign disc_after = disc_cnt_q - CW'(resp_drop);

  always_comb begin
    req_d      = req_q;
    kill_d     = kill_q;
    req_pc_d   = req_pc_q;
    owr_d      = owr_q;
    ord_d      = ord_q;
    ocnt_d     = ocnt_after;
    iwr_d      = iwr_q;
    ird_d      = ird_q;
    icnt_d     = icnt_q;
    disc_cnt_d = disc_after;

    // Requests are never withdrawn; a new accept can only follow (or coincide with) a grant.
    if (accept) begin
      req_d    = 1'b1;
      req_pc_d = pc_in;
    end else if (grant) begin
      req_d = 1'b0;
    end

    if (flush && req_q && !imem_gnt) begin
      kill_d = 1'b1;
    end else if (grant) begin
      kill_d = 1'b0;
    end

    if (flush) begin
      owr_d  = '0;
      ord_d  = '0;
      ocnt_d = '0;
      iwr_d  = '0;
      ird_d  = '0;
      icnt_d = '0;
      // Everything still owed by memory becomes a discard: outstanding ones (including a grant
      // this cycle), a live pending request, and any discards left over from an earlier flush.
      disc_cnt_d = disc_after + ocnt_after + CW'(req_q && !imem_gnt && !kill_q);
    end else begin
      owr_d  = owr_q + PW'(opush);
      ord_d  = ord_q + PW'(resp_take);
      iwr_d  = iwr_q + PW'(resp_take);
      ird_d  = ird_q + PW'(ipop);
      icnt_d = icnt_q + CW'(resp_take) - CW'(ipop);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_q      <= 1'b0;
      kill_q     <= 1'b0;
      req_pc_q   <= '0;
      owr_q      <= '0;
      ord_q      <= '0;
      ocnt_q     <= '0;
      iwr_q      <= '0;
      ird_q      <= '0;
      icnt_q     <= '0;
      disc_cnt_q <= '0;
    end else begin
      req_q      <= req_d;
      kill_q     <= kill_d;
      req_pc_q   <= req_pc_d;
      owr_q      <= owr_d;
      ord_q      <= ord_d;
      ocnt_q     <= ocnt_d;
      iwr_q      <= iwr_d;
      ird_q      <= ird_d;
      icnt_q     <= icnt_d;
      disc_cnt_q <= disc_cnt_d;
    end
  end

  // Storage arrays carry no reset; their contents are only visible through the counters.
  always_ff @(posedge clk) begin
    if (opush) begin
      opc_q[owr_q] <= req_pc_q;
    end
    if (resp_take) begin
      ipc_q[iwr_q]  <= opc_q[ord_q];
      idat_q[iwr_q] <= imem_rdata;
    end
  end

  assign imem_req   = req_q;
  assign imem_addr  = {req_pc_q[31:2], 2'b00};
  assign inst_valid = (icnt_q != '0);
  // Outputs read as zero while empty so reset clears them without resetting the arrays.
  assign inst       = inst_valid ? idat_q[ird_q] : '0;
  assign inst_pc    = inst_valid ? ipc_q[ird_q]  : '0;

endmodule
